// File: rtl/image_rom_arbiter_pkg.sv
// Shared types and constants for the ImageROM access path.
// Pixel vectors are LANES x 32-bit, lane 0 in the least significant bits.
package image_pkg;
  localparam int PIXEL_W  = 32;
  localparam int LANES    = 4;
  localparam int DATA_W   = LANES * PIXEL_W;
  localparam int ADDR_W   = 128;
  localparam int LEN_W    = 4;
  localparam int ID_MAX_W = 2;

  typedef logic [LANES-1:0][PIXEL_W-1:0] pixel_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                last;
  } rsp_tag_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/image_rom_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Zero latency; o_any low means nothing is granted.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end
endmodule

// File: rtl/image_rom_arbiter.sv
// Shares the single-port ImageROM between requesters: round-robin burst grant, one beat per cycle.
// Responses are tagged with owner id and last flag, aligned to the ROM read latency; no backpressure.
module image_rom_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 128,
  parameter int DATA_W  = 128,
  parameter int LANES   = 4,
  parameter int LEN_W   = 4,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_rd,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_last,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);
  import image_pkg::*;

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [LEN_W-1:0]  r_beats_left;
  rsp_tag_t          r_tag [ROM_LAT];
  rsp_tag_t          w_push_tag;
  logic [N_REQ-1:0]  w_gnt_oh;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_gnt_any;
  logic              w_grant;
  logic              w_last_beat;
  logic              w_tags_busy;
  logic              w_unused_id;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  assign w_grant     = (r_state == IDLE) && w_gnt_any;
  assign w_last_beat = (r_state == BURST) && (r_beats_left == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_gnt_any) w_next_state = BURST;
      BURST:   if (w_last_beat) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == IDLE) ? w_gnt_oh : '0;
    w_push_tag = '0;
    if (r_state == BURST) begin
      w_push_tag.valid = 1'b1;
      w_push_tag.id    = ID_MAX_W'(r_cur_id);
      w_push_tag.last  = w_last_beat;
    end
  end

  // r_rom_addr doubles as the burst cursor; it only advances while more beats remain,
  // so it holds the last issued address once the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr   <= '0;
      r_beats_left <= '0;
      r_cur_id     <= '0;
      r_rr_ptr     <= '0;
    end else if (w_grant) begin
      r_rom_addr   <= req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
      r_beats_left <= req_len[int'(w_gnt_idx)*LEN_W +: LEN_W];
      r_cur_id     <= w_gnt_idx;
    end else if (r_state == BURST) begin
      if (w_last_beat) begin
        r_rr_ptr <= ID_W'(wrap_inc(int'(r_cur_id), N_REQ));
      end else begin
        r_rom_addr   <= r_rom_addr + ADDR_W'(LANES);
        r_beats_left <= r_beats_left - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_push_tag;
      for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_tags_busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) w_tags_busy = w_tags_busy | r_tag[i].valid;
  end

  assign rom_addr    = r_rom_addr;
  assign rsp_valid   = r_tag[ROM_LAT-1].valid;
  assign rsp_id      = r_tag[ROM_LAT-1].id[ID_W-1:0];
  assign rsp_last    = r_tag[ROM_LAT-1].last;
  assign rsp_data    = rom_rd;
  assign busy        = (r_state == BURST) || w_tags_busy;
  assign w_unused_id = ^r_tag[ROM_LAT-1].id;
endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter with a registered ROM model (latency 1) and a response scoreboard.
module tb_image_rom_arbiter;
  localparam int NR = 2;
  localparam int AW = 128;
  localparam int DW = 128;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     req_ready;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_rd;
  logic              rsp_valid;
  logic [0:0]        rsp_id;
  logic              rsp_last;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  image_rom_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LANES(4), .LEN_W(LW), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .rom_addr(rom_addr), .rom_rd(rom_rd), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rom_model(input logic [127:0] a);
    logic [127:0] v;
    v = '0;
    case (a)
      128'd0:     v = {32'd118, 32'd114, 32'd108, 32'd106};
      128'd40000: v = {32'd170, 32'd166, 32'd161, 32'd159};
      128'd80000: v = {32'd98,  32'd94,  32'd89,  32'd87};
      default:
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = a[31:0] * 32'd7 + 32'(i * 13) + 32'h100;
    endcase
    return v;
  endfunction

  always @(posedge clk) rom_rd <= rom_model(rom_addr);

  typedef struct {
    logic [0:0]   id;
    logic         last;
    logic [127:0] addr;
    logic [127:0] data;
  } sb_item_t;

  typedef struct {
    int           id;
    logic [127:0] addr;
    logic [3:0]   len;
    logic [127:0] exp_first;
    logic [127:0] exp_last_addr;
    int           exp_cyc;
  } vec_t;

  sb_item_t     sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] prev_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input int id, input logic [127:0] addr, input logic [3:0] len);
    sb_item_t it;
    for (int i = 0; i <= int'(len); i++) begin
      it.id   = 1'(id);
      it.last = (i == int'(len));
      it.addr = addr + 128'(4 * i);
      it.data = rom_model(it.addr);
      sb_q.push_back(it);
    end
  endtask

  // Scoreboard consumer: every response beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_item_t it;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 128'(rsp_valid), 128'd0);
      end else begin
        it = sb_q.pop_front();
        check("rsp_id",   128'(rsp_id),   128'(it.id));
        check("rsp_last", 128'(rsp_last), 128'(it.last));
        check("rsp_data", rsp_data,       it.data);
        check("rom_addr", prev_addr,      it.addr);
      end
    end
    prev_addr = rom_addr;
  end

  // Caller must be at a falling edge with the arbiter idle.
  task automatic run_req(input int id, input logic [127:0] addr, input logic [3:0] len,
                         output logic [127:0] first, output logic [127:0] last_addr, output int cyc);
    bit got;
    bit seen_first;
    bit done;
    first = '0;
    last_addr = '0;
    cyc = 0;
    req_addr[id*AW +: AW] = addr;
    req_len[id*LW +: LW]  = len;
    req_valid[id]         = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (req_ready[id]) got = 1;
      else @(negedge clk);
    end
    check("grant", 128'(got), 128'd1);
    if (!got) begin
      req_valid[id] = 1'b0;
      return;
    end
    push_burst(id, addr, len);
    @(negedge clk);
    req_valid[id]         = 1'b0;
    req_addr[id*AW +: AW] = ~addr;
    req_len[id*LW +: LW]  = ~len;
    cyc = 1;
    seen_first = 0;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (rsp_valid && !seen_first) begin
        first = rsp_data;
        seen_first = 1;
      end
      if (rsp_valid && rsp_last) begin
        last_addr = prev_addr;
        check("busy_at_last", 128'(busy), 128'd1);
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("burst_done", 128'(done), 128'd1);
    @(negedge clk);
    #1;
    check("busy_after", 128'(busy), 128'd0);
  endtask

  vec_t vecs[5];
  int   exp_order[4];

  initial begin
    logic [127:0] first, last_addr;
    int cyc;
    int k, last_g, gid;
    bit drained;

    vecs[0] = '{0, 128'd0,     4'd0,  {32'd118, 32'd114, 32'd108, 32'd106}, 128'd0,     2};
    vecs[1] = '{1, 128'd40000, 4'd2,  {32'd170, 32'd166, 32'd161, 32'd159}, 128'd40008, 4};
    vecs[2] = '{0, ~128'd3,    4'd1,  rom_model(~128'd3),                    128'd0,     3};
    vecs[3] = '{1, 128'd100,   4'd15, rom_model(128'd100),                   128'd160,   17};
    vecs[4] = '{0, 128'd80000, 4'd3,  {32'd98, 32'd94, 32'd89, 32'd87},      128'd80012, 5};
    exp_order = '{0, 1, 0, 1};

    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rom_addr",  rom_addr,            128'd0);
    check("reset_req_ready", 128'(req_ready),     128'd0);
    check("reset_rsp",       {rsp_valid, rsp_last, rsp_id}, 128'd0);
    check("reset_busy",      128'(busy),          128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_req(vecs[v].id, vecs[v].addr, vecs[v].len, first, last_addr, cyc);
      check("first_beat", first,        vecs[v].exp_first);
      check("last_addr",  last_addr,    vecs[v].exp_last_addr);
      check("cycles",     128'(cyc),    128'(vecs[v].exp_cyc));
      @(negedge clk);
    end

    // Reset in the middle of an 8-beat burst; rr_ptr was 1 before this.
    req_addr[0 +: AW] = 128'd80000;
    req_len[0 +: LW]  = 4'd7;
    req_valid[0]      = 1'b1;
    #1;
    check("mid_grant", 128'(req_ready), 128'd1);
    push_burst(0, 128'd80000, 4'd7);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    #1;
    check("mid_rsp_valid", 128'(rsp_valid), 128'd0);
    check("mid_rom_addr",  rom_addr,        128'd0);
    check("mid_busy",      128'(busy),      128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Contention straight after reset: both held, alternating grants.
    req_addr[0 +: AW]  = 128'd0;
    req_addr[AW +: AW] = 128'd40000;
    req_len            = '0;
    req_valid          = 2'b11;
    k = 0;
    last_g = 0;
    for (int n = 0; n < 30 && k < 4; n++) begin
      #1;
      if (req_ready != '0) begin
        check("onehot", 128'($onehot(req_ready)), 128'd1);
        gid = req_ready[1] ? 1 : 0;
        check("grant_order", 128'(gid), 128'(exp_order[k]));
        if (k > 0) check("grant_gap", 128'(n - last_g), 128'd2);
        push_burst(gid, gid == 1 ? 128'd40000 : 128'd0, 4'd0);
        last_g = n;
        k++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("grant_count", 128'(k), 128'd4);
    drained = 0;
    for (int n = 0; n < 20 && !drained; n++) begin
      #1;
      if (!busy) drained = 1;
      else @(negedge clk);
    end
    check("contention_drain", 128'(drained), 128'd1);
    @(negedge clk);

    run_req(0, 128'd80000, 4'd0, first, last_addr, cyc);
    check("post_reset_lanes", first, {32'd98, 32'd94, 32'd89, 32'd87});
    check("post_reset_cyc",   128'(cyc), 128'd2);

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_rom_arbiter.md
Name: image_rom_arbiter

Overview:
- Shares the single-port ImageROM between N_REQ requesters, e.g. the vector load unit (foreground/background pixel fetch) and the output streamer.
- Each requester posts a burst request: a start pixel address and a beat count.
- The arbiter grants round-robin, drives the ROM address one beat per cycle (stride LANES pixels) and returns 128-bit vector data tagged with requester id and last-beat flag.
- Sits between the ROM and the vector register-file load path.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ADDR_W, 128, ROM address width (pixel index).
- DATA_W, 128, ROM read width (LANES x 32-bit pixels).
- LANES, 4, pixels per beat; address stride per beat.
- LEN_W, 4, burst length field width; beats = req_len+1 (1..16).
- ROM_LAT, 1, cycles from rom_addr to valid rom_rd.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_addr  in  N_REQ*ADDR_W  start pixel address, requester i in slice i.
- req_len  in  N_REQ*LEN_W  beats minus one.
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- rom_addr  out  ADDR_W  address to ImageROM.
- rom_rd  in  DATA_W  ImageROM read data.
- rsp_valid  out  1  rsp_data valid this cycle.
- rsp_id  out  clog2(N_REQ)  owner of the current beat.
- rsp_last  out  1  final beat of the burst.
- rsp_data  out  DATA_W  rom_rd passed through.
- busy  out  1  high in BURST or while beats are in flight.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, rom_addr=0, req_ready=0, rsp_valid=0, rsp_last=0, rsp_id=0, busy=0, tag pipeline cleared.
- FSM states: IDLE, BURST.
- IDLE, no req_valid: stay; rom_addr holds its last value.
- IDLE, any req_valid:
  - Grant the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Assert req_ready[g] for exactly this cycle.
  - Latch cur_addr=req_addr[g], beats_left=req_len[g], cur_id=g.
  - Next state BURST.
- BURST, each cycle:
  - rom_addr=cur_addr.
  - Push tag {valid=1, id=cur_id, last=(beats_left==0)} into the ROM_LAT-deep tag pipeline.
  - cur_addr += LANES (mod 2^ADDR_W, wraps silently); beats_left -= 1.
  - After the beat with beats_left==0: rr_ptr=(cur_id+1) mod N_REQ, next state IDLE.
- Cadence: one IDLE arbitration cycle between bursts; burst of L+1 beats occupies L+2 cycles.
- Response:
  - rsp_valid/rsp_id/rsp_last come from the tag pipeline output.
  - rsp_data=rom_rd, aligned so a beat issued at cycle t appears at t+ROM_LAT.
  - No response backpressure; the consumer must accept every beat.
- Request rules:
  - The requester holds req_valid/req_addr/req_len stable until req_ready.
  - Inputs are sampled only in the grant cycle; changing them mid-burst has no effect.
  - A requester may re-request right after its burst; round-robin prevents starvation when others are pending.
- busy = (state==BURST) OR any tag-pipeline valid.
- Reset mid-burst: burst abandoned, tags flushed; rsp_valid=0 the cycle after rst is sampled; no partial response completes later.
- Simultaneous req_valid from all requesters: exactly one grant; the others wait with req_ready=0.

Decomposition:
- Shared package image_pkg: LANES, PIXEL_W=32, DATA_W, ADDR_W, typedef pixel_vec_t (LANES x 32-bit), typedef arb_state_e {IDLE, BURST}, typedef rsp_tag_t {valid, id, last}.
- Sub-module rr_arbiter: combinational round-robin first-set search from rr_ptr, outputs a one-hot grant and an index. Reusable by the future register-file write-port arbiter.

Test Plan:
- Single beat, req0 addr=0, len=0:
  - req_ready[0] pulses in the IDLE cycle.
  - Next cycle rom_addr=0.
  - ROM_LAT later: rsp_valid=1, rsp_id=0, rsp_last=1, lanes 106,108,114,118.
- Burst, req1 addr=40000, len=2:
  - rom_addr=40000, 40004, 40008 on consecutive cycles.
  - First response lanes 159,161,166,170, rsp_id=1.
  - rsp_last only on the third beat; busy drops after it.
- Contention after reset, req0 and req1 both held, len=0:
  - Grant order req0, req1, req0, req1.
  - One idle cycle between bursts; never two consecutive grants to the same requester.
- Address wrap, req0 addr=2^128-4, len=1:
  - rom_addr=2^128-4 then 0.
  - Two beats; rsp_last on the second.
- Reset mid-burst, req0 addr=80000, len=7:
  - Assert rst after beat 2; rsp_valid=0 from the next cycle.
  - rom_addr=0, state IDLE, rr_ptr=0.
  - A new req0 addr=80000 len=0 then returns lanes 87,89,94,98.
- Stable-input check, req0 len=3:
  - Change req_addr/req_len after req_ready.
  - Issued addresses still follow the latched values: 4 beats, stride 4.
